// File: rtl/maquina_cafe_pkg.sv
// Shared definitions for the parametrised coffee-machine controller:
// state encoding, error codes and the status colour shown in each state.
package maquina_cafe_pkg;

    typedef enum logic [2:0] {
        REPOUSO   = 3'd0,
        ESCOLHA   = 3'd1,
        PAGAMENTO = 3'd2,
        PREPARO   = 3'd3,
        TROCO     = 3'd4,
        ERRO      = 3'd5
    } estado_e;

    localparam logic [1:0] ERRO_NENHUM  = 2'd0;
    localparam logic [1:0] ERRO_SENSOR  = 2'd1;
    localparam logic [1:0] ERRO_PRODUTO = 2'd2;

    localparam logic [2:0] RGB_REPOUSO   = 3'b001;
    localparam logic [2:0] RGB_ESCOLHA   = 3'b011;
    localparam logic [2:0] RGB_PAGAMENTO = 3'b110;
    localparam logic [2:0] RGB_PREPARO   = 3'b010;
    localparam logic [2:0] RGB_TROCO     = 3'b101;
    localparam logic [2:0] RGB_ERRO      = 3'b100;

    // Status colour {R,G,B} for a given state.
    function automatic logic [2:0] rgb_of(input estado_e s);
        logic [2:0] rgb;
        case (s)
            REPOUSO:   rgb = RGB_REPOUSO;
            ESCOLHA:   rgb = RGB_ESCOLHA;
            PAGAMENTO: rgb = RGB_PAGAMENTO;
            PREPARO:   rgb = RGB_PREPARO;
            TROCO:     rgb = RGB_TROCO;
            ERRO:      rgb = RGB_ERRO;
            default:   rgb = RGB_ERRO;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/maquina_cafe_if.sv
// Front-panel bundle of the coffee machine: buttons, note acceptor, price
// table and sensors toward the controller; state, money and indicators back.
interface maquina_cafe_if #(
    parameter int NUM_PROD = 4,
    parameter int VAL_W    = 4,
    parameter int CRED_W   = 6,
    parameter int NUM_SENS = 3
);
    localparam int SEL_W = $clog2(NUM_PROD);

    logic                      TICK;
    logic                      CONFIRMA;
    logic                      INSERIR;
    logic                      CANCELA;
    logic [VAL_W-1:0]          VALOR_NOTA;
    logic [SEL_W-1:0]          PRODUTO;
    logic [NUM_PROD*VAL_W-1:0] PRECOS;
    logic [NUM_SENS-1:0]       SENSORES;

    logic [2:0]                ESTADO;
    logic [CRED_W-1:0]         CREDITO;
    logic [CRED_W-1:0]         TROCO;
    logic [NUM_PROD-1:0]       LED_PREPARO;
    logic [1:0]                ERRO_COD;
    logic [2:0]                RGB;

    modport master (
        output TICK, CONFIRMA, INSERIR, CANCELA, VALOR_NOTA, PRODUTO, PRECOS, SENSORES,
        input  ESTADO, CREDITO, TROCO, LED_PREPARO, ERRO_COD, RGB
    );

    modport slave (
        input  TICK, CONFIRMA, INSERIR, CANCELA, VALOR_NOTA, PRODUTO, PRECOS, SENSORES,
        output ESTADO, CREDITO, TROCO, LED_PREPARO, ERRO_COD, RGB
    );

endinterface

// File: rtl/maquina_cafe_tick_timer.sv
// TICK counter shared by all timed states; done flags the tick that reaches
// the limit so the controller can leave the state on that same cycle.
module tick_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   next_s;

    // Next count; clear beats enable so a reload on a tick starts from zero.
    always_comb begin
        next_s = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
        done   = enable && (next_s >= {1'b0, limit});
        if (clear) begin
            count_d = '0;
        end else if (enable && !next_s[WIDTH]) begin
            count_d = next_s[WIDTH-1:0];
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/maquina_cafe_param.sv
// Parametrised coffee-machine controller: product choice, saturating credit,
// brewing with sensor supervision, change/refund and fault recovery.
module maquina_cafe_param
    import maquina_cafe_pkg::*;
#(
    parameter int NUM_PROD  = 4,
    parameter int VAL_W     = 4,
    parameter int CRED_W    = 6,
    parameter int NUM_SENS  = 3,
    parameter int T_PREPARO = 8,
    parameter int T_TROCO   = 2,
    parameter int T_TIMEOUT = 30
) (
    input logic           CLK,
    input logic           RST_N,
    maquina_cafe_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_PROD);
    localparam int T_MAX_A = (T_PREPARO > T_TROCO) ? T_PREPARO : T_TROCO;
    localparam int T_MAX   = (T_MAX_A > T_TIMEOUT) ? T_MAX_A : T_TIMEOUT;
    localparam int TMR_W   = $clog2(T_MAX + 1);

    estado_e             state_q, state_d;
    logic [SEL_W-1:0]    prod_q, prod_d;
    logic [VAL_W-1:0]    price_q, price_d;
    logic [CRED_W-1:0]   credito_q, credito_d;
    logic [CRED_W-1:0]   troco_q, troco_d;
    logic [NUM_PROD-1:0] led_q, led_d;
    logic [1:0]          erro_q, erro_d;
    logic [2:0]          rgb_q, rgb_d;

    logic [VAL_W-1:0]    sel_price_s;
    logic                prod_valid_s;
    logic                sens_ok_s;
    logic                tmr_clear_s;
    logic                tmr_enable_s;
    logic [TMR_W-1:0]    tmr_limit_s;
    logic                tmr_done_s;

    function automatic logic [CRED_W-1:0] sat_add(input logic [CRED_W-1:0] a,
                                                  input logic [VAL_W-1:0]  b);
        logic [CRED_W:0] sum;
        sum = {1'b0, a} + (CRED_W+1)'(b);
        if (sum[CRED_W]) begin
            return '1;
        end else begin
            return sum[CRED_W-1:0];
        end
    endfunction

    assign sens_ok_s    = &bus.SENSORES;
    assign prod_valid_s = (32'(bus.PRODUTO) < 32'(NUM_PROD));

    // Price of the product currently on the selection switches.
    always_comb begin
        sel_price_s = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            sel_price_s = (bus.PRODUTO == SEL_W'(i)) ? bus.PRECOS[i*VAL_W +: VAL_W] : sel_price_s;
        end
    end

    // Timer limit and tick gating for the state being timed.
    always_comb begin
        tmr_limit_s  = '0;
        tmr_enable_s = 1'b0;
        case (state_q)
            PAGAMENTO: begin
                tmr_limit_s  = TMR_W'(T_TIMEOUT);
                tmr_enable_s = bus.TICK;
            end
            PREPARO: begin
                tmr_limit_s  = TMR_W'(T_PREPARO);
                tmr_enable_s = bus.TICK;
            end
            TROCO: begin
                tmr_limit_s  = TMR_W'(T_TROCO);
                tmr_enable_s = bus.TICK;
            end
            default: begin
                tmr_limit_s  = '0;
                tmr_enable_s = 1'b0;
            end
        endcase
    end

    // Any state change reloads the timer; an accepted note restarts the payment timeout.
    assign tmr_clear_s = (state_d != state_q) || ((state_q == PAGAMENTO) && bus.INSERIR);

    tick_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clear  (tmr_clear_s),
        .enable (tmr_enable_s),
        .limit  (tmr_limit_s),
        .done   (tmr_done_s)
    );

    // Next-state and next-output logic of the controller.
    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        price_d   = price_q;
        credito_d = credito_q;
        troco_d   = troco_q;
        erro_d    = erro_q;
        case (state_q)
            REPOUSO: begin
                if (!sens_ok_s) begin
                    state_d = ERRO;
                    erro_d  = ERRO_SENSOR;
                end else if (bus.CONFIRMA) begin
                    state_d = ESCOLHA;
                end else begin
                    state_d = REPOUSO;
                end
            end
            ESCOLHA: begin
                if (bus.CONFIRMA) begin
                    if (prod_valid_s) begin
                        prod_d  = bus.PRODUTO;
                        price_d = sel_price_s;
                        state_d = PAGAMENTO;
                    end else begin
                        state_d = ERRO;
                        erro_d  = ERRO_PRODUTO;
                    end
                end else if (bus.CANCELA) begin
                    state_d = REPOUSO;
                end else begin
                    state_d = ESCOLHA;
                end
            end
            PAGAMENTO: begin
                // A note arriving with the cancel is rejected, and a note on the
                // timeout tick keeps the customer paying.
                if (bus.CANCELA || (tmr_done_s && !bus.INSERIR)) begin
                    state_d = TROCO;
                    troco_d = credito_q;
                end else begin
                    if (bus.INSERIR) begin
                        credito_d = sat_add(credito_q, bus.VALOR_NOTA);
                    end else begin
                        credito_d = credito_q;
                    end
                    if (credito_d >= CRED_W'(price_q)) begin
                        state_d = PREPARO;
                    end else begin
                        state_d = PAGAMENTO;
                    end
                end
            end
            PREPARO: begin
                if (!sens_ok_s) begin
                    state_d = TROCO;
                    troco_d = credito_q;
                    erro_d  = ERRO_SENSOR;
                end else if (tmr_done_s) begin
                    state_d = TROCO;
                    troco_d = credito_q - CRED_W'(price_q);
                end else begin
                    state_d = PREPARO;
                end
            end
            TROCO: begin
                if (tmr_done_s) begin
                    credito_d = '0;
                    troco_d   = '0;
                    state_d   = (erro_q != ERRO_NENHUM) ? ERRO : REPOUSO;
                end else begin
                    state_d = TROCO;
                end
            end
            ERRO: begin
                if (bus.CONFIRMA && sens_ok_s) begin
                    state_d = REPOUSO;
                    erro_d  = ERRO_NENHUM;
                end else begin
                    state_d = ERRO;
                end
            end
            default: begin
                state_d = REPOUSO;
                erro_d  = ERRO_NENHUM;
            end
        endcase
        led_d = (state_d == PREPARO) ? (NUM_PROD'(1) << prod_d) : '0;
        rgb_d = rgb_of(state_d);
    end

    // Controller state and every output register, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= REPOUSO;
            prod_q    <= '0;
            price_q   <= '0;
            credito_q <= '0;
            troco_q   <= '0;
            led_q     <= '0;
            erro_q    <= ERRO_NENHUM;
            rgb_q     <= RGB_REPOUSO;
        end else begin
            state_q   <= state_d;
            prod_q    <= prod_d;
            price_q   <= price_d;
            credito_q <= credito_d;
            troco_q   <= troco_d;
            led_q     <= led_d;
            erro_q    <= erro_d;
            rgb_q     <= rgb_d;
        end
    end

    assign bus.ESTADO      = state_q;
    assign bus.CREDITO     = credito_q;
    assign bus.TROCO       = troco_q;
    assign bus.LED_PREPARO = led_q;
    assign bus.ERRO_COD    = erro_q;
    assign bus.RGB         = rgb_q;

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Self-checking bench for maquina_cafe_param: vector table plus hand-written
// timeout and sensor-fault sequences, expectations queued per driven cycle.
module tb_maquina_cafe_param;

    localparam int NP = 4;
    localparam int VW = 6;
    localparam int CW = 6;
    localparam int NS = 3;

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_TICK = 4'b1000;
    localparam logic [3:0] P_CONF = 4'b0100;
    localparam logic [3:0] P_INS  = 4'b0010;
    localparam logic [3:0] P_CANC = 4'b0001;
    localparam logic [2:0] S_OK   = 3'b111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    maquina_cafe_if #(.NUM_PROD(NP), .VAL_W(VW), .CRED_W(CW), .NUM_SENS(NS)) bus ();

    maquina_cafe_param #(
        .NUM_PROD(NP), .VAL_W(VW), .CRED_W(CW), .NUM_SENS(NS),
        .T_PREPARO(8), .T_TROCO(2), .T_TIMEOUT(30)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        bit         rst;
        logic [3:0] p;
        int         nota;
        int         prod;
        logic [2:0] sens;
        int         e, c, t, l, r;
    } vec_t;

    typedef struct {
        string name;
        int    e, c, t, l, r;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string n, logic [3:0] p, int nota, int prod, logic [2:0] s,
                                int e, int c, int t, int l, int r);
        vec_t v;
        v.name = n; v.rst = 1'b0; v.p = p; v.nota = nota; v.prod = prod; v.sens = s;
        v.e = e; v.c = c; v.t = t; v.l = l; v.r = r;
        return v;
    endfunction

    function automatic vec_t mk_rst(string n, int prod);
        vec_t v;
        v = mk(n, P_NONE, 0, prod, S_OK, 0, 0, 0, 0, 0);
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic int rgb_for(int e);
        case (e)
            0:       return 1;  // 001
            1:       return 3;  // 011
            2:       return 6;  // 110
            3:       return 2;  // 010
            4:       return 5;  // 101
            5:       return 4;  // 100
            default: return 0;
        endcase
    endfunction

    task automatic cmp(string n, string f, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s %s got=%0d exp=%0d", n, f, got, want);
        end
    endtask

    task automatic step(vec_t v);
        exp_t x;
        rst_n = v.rst ? 1'b0 : 1'b1;
        {bus.TICK, bus.CONFIRMA, bus.INSERIR, bus.CANCELA} = v.p;
        bus.VALOR_NOTA = 6'(v.nota);
        bus.PRODUTO    = 2'(v.prod);
        bus.SENSORES   = v.sens;
        x.name = v.name; x.e = v.e; x.c = v.c; x.t = v.t; x.l = v.l; x.r = v.r;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        {bus.TICK, bus.CONFIRMA, bus.INSERIR, bus.CANCELA} = 4'b0000;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty got=0 exp=1", v.name);
        end else begin
            x = exp_q.pop_front();
            cmp(x.name, "ESTADO",      int'(bus.ESTADO),      x.e);
            cmp(x.name, "CREDITO",     int'(bus.CREDITO),     x.c);
            cmp(x.name, "TROCO",       int'(bus.TROCO),       x.t);
            cmp(x.name, "LED_PREPARO", int'(bus.LED_PREPARO), x.l);
            cmp(x.name, "ERRO_COD",    int'(bus.ERRO_COD),    x.r);
            cmp(x.name, "RGB",         int'(bus.RGB),         rgb_for(x.e));
        end
    endtask

    task automatic ticks(string n, int k, int prod, logic [2:0] s,
                         int e, int c, int t, int l, int r);
        for (int i = 0; i < k; i++) begin
            step(mk(n, P_TICK, 0, prod, s, e, c, t, l, r));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.TICK = 1'b0; bus.CONFIRMA = 1'b0; bus.INSERIR = 1'b0; bus.CANCELA = 1'b0;
        bus.VALOR_NOTA = '0; bus.PRODUTO = '0; bus.SENSORES = S_OK;
        bus.PRECOS = {6'd63, 6'd7, 6'd5, 6'd3};

        // Reset state and idle.
        tbl.push_back(mk_rst("reset", 0));
        tbl.push_back(mk("idle", P_NONE, 0, 0, S_OK, 0, 0, 0, 0, 0));
        // Product 2 (price 7), notes 5+5: brew 8 ticks, change 3.
        tbl.push_back(mk("a_conf1", P_CONF, 0, 2, S_OK, 1, 0, 0, 0, 0));
        tbl.push_back(mk("a_conf2", P_CONF, 0, 2, S_OK, 2, 0, 0, 0, 0));
        tbl.push_back(mk("a_note5", P_INS, 5, 2, S_OK, 2, 5, 0, 0, 0));
        tbl.push_back(mk("a_note10", P_INS, 5, 2, S_OK, 3, 10, 0, 4, 0));
        tbl.push_back(mk("a_notick", P_NONE, 0, 2, S_OK, 3, 10, 0, 4, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk("a_brew", P_TICK, 0, 2, S_OK, 3, 10, 0, 4, 0));
        tbl.push_back(mk("a_brew8", P_TICK, 0, 2, S_OK, 4, 10, 3, 0, 0));
        tbl.push_back(mk("a_troco1", P_TICK, 0, 2, S_OK, 4, 10, 3, 0, 0));
        tbl.push_back(mk("a_troco2", P_TICK, 0, 2, S_OK, 0, 0, 0, 0, 0));
        // Cancel in ESCOLHA, then notes 2+1 and cancel in PAGAMENTO.
        tbl.push_back(mk("b_conf", P_CONF, 0, 2, S_OK, 1, 0, 0, 0, 0));
        tbl.push_back(mk("b_esc_canc", P_CANC, 0, 2, S_OK, 0, 0, 0, 0, 0));
        tbl.push_back(mk("b_conf1", P_CONF, 0, 2, S_OK, 1, 0, 0, 0, 0));
        tbl.push_back(mk("b_conf2", P_CONF, 0, 2, S_OK, 2, 0, 0, 0, 0));
        tbl.push_back(mk("b_note2", P_INS, 2, 2, S_OK, 2, 2, 0, 0, 0));
        tbl.push_back(mk("b_note1", P_INS, 1, 2, S_OK, 2, 3, 0, 0, 0));
        tbl.push_back(mk("b_conf_ign", P_CONF, 0, 2, S_OK, 2, 3, 0, 0, 0));
        tbl.push_back(mk("b_cancel", P_CANC, 0, 2, S_OK, 4, 3, 3, 0, 0));
        tbl.push_back(mk("b_troco1", P_TICK, 0, 2, S_OK, 4, 3, 3, 0, 0));
        tbl.push_back(mk("b_troco2", P_TICK, 0, 2, S_OK, 0, 0, 0, 0, 0));
        // Product 3 (price 63): 4x15 = 60, +15 saturates at 63.
        tbl.push_back(mk("c_conf1", P_CONF, 0, 3, S_OK, 1, 0, 0, 0, 0));
        tbl.push_back(mk("c_conf2", P_CONF, 0, 3, S_OK, 2, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk("c_note", P_INS, 15, 3, S_OK, 2, 15*i, 0, 0, 0));
        tbl.push_back(mk("c_sat", P_INS, 15, 3, S_OK, 3, 63, 0, 8, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk("c_brew", P_TICK, 0, 3, S_OK, 3, 63, 0, 8, 0));
        tbl.push_back(mk("c_brew8", P_TICK, 0, 3, S_OK, 4, 63, 0, 0, 0));
        tbl.push_back(mk("c_troco1", P_TICK, 0, 3, S_OK, 4, 63, 0, 0, 0));
        tbl.push_back(mk("c_troco2", P_TICK, 0, 3, S_OK, 0, 0, 0, 0, 0));
        // CANCELA+INSERIR together: note dropped, refund of 15.
        tbl.push_back(mk("d_conf1", P_CONF, 0, 3, S_OK, 1, 0, 0, 0, 0));
        tbl.push_back(mk("d_conf2", P_CONF, 0, 3, S_OK, 2, 0, 0, 0, 0));
        tbl.push_back(mk("d_note15", P_INS, 15, 3, S_OK, 2, 15, 0, 0, 0));
        tbl.push_back(mk("d_canc_ins", P_INS | P_CANC, 15, 3, S_OK, 4, 15, 15, 0, 0));
        tbl.push_back(mk("d_troco1", P_TICK, 0, 3, S_OK, 4, 15, 15, 0, 0));
        tbl.push_back(mk("d_troco2", P_TICK, 0, 3, S_OK, 0, 0, 0, 0, 0));
        // Sensor low in REPOUSO: ERRO until CONFIRMA with all sensors present.
        tbl.push_back(mk("e_sens_low", P_NONE, 0, 0, 3'b110, 5, 0, 0, 0, 1));
        tbl.push_back(mk("e_conf_low", P_CONF, 0, 0, 3'b110, 5, 0, 0, 0, 1));
        tbl.push_back(mk("e_conf_ok", P_CONF, 0, 0, S_OK, 0, 0, 0, 0, 0));
        // Reset mid-PAGAMENTO with credit 5 discards the credit.
        tbl.push_back(mk("f_conf1", P_CONF, 0, 2, S_OK, 1, 0, 0, 0, 0));
        tbl.push_back(mk("f_conf2", P_CONF, 0, 2, S_OK, 2, 0, 0, 0, 0));
        tbl.push_back(mk("f_note5", P_INS, 5, 2, S_OK, 2, 5, 0, 0, 0));
        tbl.push_back(mk_rst("f_reset", 2));
        tbl.push_back(mk("f_after", P_NONE, 0, 2, S_OK, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Payment timeout, restarted by a note on TICK 29.
        step(mk("g_conf1", P_CONF, 0, 2, S_OK, 1, 0, 0, 0, 0));
        step(mk("g_conf2", P_CONF, 0, 2, S_OK, 2, 0, 0, 0, 0));
        step(mk("g_note4", P_INS, 4, 2, S_OK, 2, 4, 0, 0, 0));
        ticks("g_wait28", 28, 2, S_OK, 2, 4, 0, 0, 0);
        step(mk("g_tick29_ins", P_TICK | P_INS, 0, 2, S_OK, 2, 4, 0, 0, 0));
        ticks("g_wait29", 29, 2, S_OK, 2, 4, 0, 0, 0);
        step(mk("g_timeout", P_TICK, 0, 2, S_OK, 4, 4, 4, 0, 0));
        step(mk("g_troco1", P_TICK, 0, 2, S_OK, 4, 4, 4, 0, 0));
        step(mk("g_troco2", P_TICK, 0, 2, S_OK, 0, 0, 0, 0, 0));

        // Sensor drop on TICK 3 of PREPARO with credit 9.
        step(mk("h_conf1", P_CONF, 0, 2, S_OK, 1, 0, 0, 0, 0));
        step(mk("h_conf2", P_CONF, 0, 2, S_OK, 2, 0, 0, 0, 0));
        step(mk("h_note5", P_INS, 5, 2, S_OK, 2, 5, 0, 0, 0));
        step(mk("h_note9", P_INS, 4, 2, S_OK, 3, 9, 0, 4, 0));
        ticks("h_brew", 2, 2, S_OK, 3, 9, 0, 4, 0);
        step(mk("h_fault", P_TICK, 0, 2, 3'b101, 4, 9, 9, 0, 1));
        step(mk("h_troco1", P_TICK, 0, 2, 3'b101, 4, 9, 9, 0, 1));
        step(mk("h_troco2", P_TICK, 0, 2, 3'b101, 5, 0, 0, 0, 1));
        step(mk("h_conf_low", P_CONF, 0, 2, 3'b101, 5, 0, 0, 0, 1));
        step(mk("h_conf_ok", P_CONF, 0, 2, S_OK, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
